// File: rtl/fx2_slave_fifo_streamer_if.sv
// -----------------------------------------------------------------------------
// fx2_slave_fifo_streamer_if
//
// Purpose:
//   Groups the sample-stream input and the FX2LP slave-FIFO write bus that
//   fx2_slave_fifo_streamer sits between.
//
// Signals:
//   s_data       sample word from the DSP chain (ch0 in the least significant bytes)
//   s_valid      one-cycle strobe per sample word, no backpressure
//   flag_full_n  FX2 endpoint FULL flag, active low
//   fd           8-bit FX2 data bus
//   slwr_n       FX2 write strobe, active low
//   pktend_n     FX2 packet end strobe, active low
//
// Modports:
//   master  the streamer: consumes samples and the FULL flag, drives the FX2 bus
//   slave   the environment: supplies samples and the FULL flag, observes the bus
// -----------------------------------------------------------------------------
interface fx2_slave_fifo_streamer_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              flag_full_n;
   logic [7:0]        fd;
   logic              slwr_n;
   logic              pktend_n;

   modport master (
      input  s_data,
      input  s_valid,
      input  flag_full_n,
      output fd,
      output slwr_n,
      output pktend_n
   );

   modport slave (
      output s_data,
      output s_valid,
      output flag_full_n,
      input  fd,
      input  slwr_n,
      input  pktend_n
   );
endinterface

// File: rtl/fx2_slave_fifo_streamer.sv
// -----------------------------------------------------------------------------
// fx2_slave_fifo_streamer
//
// Purpose:
//   Tail of the SDR chain. Buffers NUM_CH-channel sample words coming from the
//   CIC/FIR stages, serialises each word little-endian onto the FX2LP 8-bit
//   slave-FIFO data bus and strobes SLWR#. Stalls while the FX2 endpoint reports
//   FULL, counts words dropped because the buffer had no room, and commits a
//   partial packet with PKTEND# when a flush is requested.
//
// Parameters:
//   NUM_CH        channels per sample word (ch0 in the LS bytes, sent first)
//   SAMPLE_BYTES  bytes per channel
//   FIFO_DEPTH    input buffer depth in words (power of 2, >= 2)
//   PKT_BYTES     FX2 endpoint packet size in bytes
//
// Ports:
//   clk          stream clock (IFCLK domain), all logic on the rising edge
//   reset_n      synchronous active-low reset
//   enable_i     1 = accept input words (buffered words drain regardless)
//   flush_i      pulse: commit the partial packet once the buffer has drained
//   testpat_i    (only with FX2_STREAM_TESTPAT_EN) 1 = send counter bytes
//   bus          master side of fx2_slave_fifo_streamer_if (samples in, FX2 bus out)
//   ovf_count_o  dropped-word counter, saturating at 16'hFFFF
//   level_o      number of words held in the input buffer
//
// Configuration:
//   FX2_STREAM_TESTPAT_EN  when defined, adds testpat_i and an 8-bit counter that
//                          replaces the data bytes on fd while testpat_i is high.
//                          When undefined, fd always carries buffered data.
// -----------------------------------------------------------------------------
module fx2_slave_fifo_streamer #(
   parameter int NUM_CH       = 2,
   parameter int SAMPLE_BYTES = 2,
   parameter int FIFO_DEPTH   = 16,
   parameter int PKT_BYTES    = 512
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        enable_i,
   input  logic                        flush_i,
`ifdef FX2_STREAM_TESTPAT_EN
   input  logic                        testpat_i,
`endif
   fx2_slave_fifo_streamer_if.master   bus,
   output logic [15:0]                 ovf_count_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o
);

   localparam int WORD_BYTES = NUM_CH * SAMPLE_BYTES;
   localparam int DATA_W     = WORD_BYTES * 8;
   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int IW         = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int PW         = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;

   localparam logic [AW:0]   DEPTH_L  = (AW+1)'(FIFO_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
   localparam logic [PW-1:0] PKT_LAST = PW'(PKT_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      PKTEND = 2'd2
   } state_t;

   // Buffer storage and the word being serialised carry no reset: only the
   // pointers/count decide what is valid.
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] word_q, word_d;

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [15:0]       ovf_q, ovf_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [PW-1:0]     pkt_q, pkt_d;
   logic              flush_q, flush_d;
   logic [7:0]        fd_q, fd_d;
   logic              slwr_n_q, slwr_n_d;
   logic              pktend_n_q, pktend_n_d;
`ifdef FX2_STREAM_TESTPAT_EN
   logic [7:0]        tp_q, tp_d;
`endif

   logic              push_req;
   logic              push_ok;
   logic              pop;
   logic              flush_clr;
   logic              write;
   logic [7:0]        cur_byte;

   // Byte currently addressed inside the held word, LS byte first.
   assign cur_byte = word_q[{idx_q, 3'b000} +: 8];

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      idx_d      = idx_q;
      pkt_d      = pkt_q;
      fd_d       = fd_q;
      slwr_n_d   = 1'b1;
      pktend_n_d = 1'b1;
      pop        = 1'b0;
      flush_clr  = 1'b0;
      write      = 1'b0;

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               word_d  = mem_q[rd_ptr_q];
               idx_d   = '0;
               state_d = SEND;
            end else if (flush_q) begin
               // An empty packet is never committed; the request is simply consumed.
               flush_clr = 1'b1;
               if (pkt_q != '0) begin
                  state_d    = PKTEND;
                  pkt_d      = '0;
                  pktend_n_d = 1'b0;
               end
            end
         end

         SEND: begin
            // With FULL asserted nothing moves, so the byte is retried next cycle.
            if (bus.flag_full_n) begin
               write    = 1'b1;
               slwr_n_d = 1'b0;
`ifdef FX2_STREAM_TESTPAT_EN
               fd_d     = testpat_i ? tp_q : cur_byte;
`else
               fd_d     = cur_byte;
`endif
               pkt_d    = (pkt_q == PKT_LAST) ? '0 : pkt_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  if (count_q != '0) begin
                     // Reload in the same cycle so words stream without a gap.
                     pop    = 1'b1;
                     word_d = mem_q[rd_ptr_q];
                     idx_d  = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         PKTEND: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Buffer bookkeeping, overflow counter and flush latch
   // -------------------------------------------------------------------------
   assign push_req = bus.s_valid & enable_i;
   // A full buffer still takes a word when a slot is freed in the same cycle.
   assign push_ok  = push_req & ((count_q < DEPTH_L) | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (push_req && !push_ok && (ovf_q != 16'hFFFF)) begin
         ovf_d = ovf_q + 16'd1;
      end
   end

   // A new request wins over the clear so a flush arriving while one is being
   // serviced is kept for the next pass through IDLE.
   assign flush_d = flush_i | (flush_q & ~flush_clr);

`ifdef FX2_STREAM_TESTPAT_EN
   assign tp_d = write ? tp_q + 8'd1 : tp_q;
`endif

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= '0;
         idx_q      <= '0;
         pkt_q      <= '0;
         flush_q    <= 1'b0;
         fd_q       <= '0;
         slwr_n_q   <= 1'b1;
         pktend_n_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         idx_q      <= idx_d;
         pkt_q      <= pkt_d;
         flush_q    <= flush_d;
         fd_q       <= fd_d;
         slwr_n_q   <= slwr_n_d;
         pktend_n_q <= pktend_n_d;
      end
   end

`ifdef FX2_STREAM_TESTPAT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tp_q <= '0;
      end else begin
         tp_q <= tp_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= bus.s_data;
      end
      word_q <= word_d;
   end

   assign bus.fd       = fd_q;
   assign bus.slwr_n   = slwr_n_q;
   assign bus.pktend_n = pktend_n_q;
   assign ovf_count_o  = ovf_q;
   assign level_o      = count_q;

endmodule

// File: tb/tb_fx2_slave_fifo_streamer.sv
// -----------------------------------------------------------------------------
// tb_fx2_slave_fifo_streamer
//
// Purpose:
//   Directed self-checking bench for fx2_slave_fifo_streamer with default
//   parameters (2 ch x 2 bytes, 16-word buffer, 512-byte packets). Inputs change
//   1 time unit after the rising edge; a negedge monitor logs every FX2 write
//   and PKTEND# pulse with its cycle number.
//   The counter test pattern section is built only with FX2_STREAM_TESTPAT_EN.
// -----------------------------------------------------------------------------
module tb_fx2_slave_fifo_streamer;

   logic        clk;
   logic        reset_n;
   logic        enable;
   logic        flush;
`ifdef FX2_STREAM_TESTPAT_EN
   logic        testpat;
`endif
   logic [15:0] ovf_count;
   logic [4:0]  level;

   int n_cmp = 0;
   int n_bad = 0;

   fx2_slave_fifo_streamer_if #(.DATA_W(32)) bus ();

   fx2_slave_fifo_streamer dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable_i    (enable),
      .flush_i     (flush),
`ifdef FX2_STREAM_TESTPAT_EN
      .testpat_i   (testpat),
`endif
      .bus         (bus),
      .ovf_count_o (ovf_count),
      .level_o     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write / packet-end log.
   logic [7:0] wr_q [$];
   int         wr_cyc_q [$];
   int         pe_cyc_q [$];
   int         cyc = 0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.slwr_n === 1'b0) begin
         wr_q.push_back(bus.fd);
         wr_cyc_q.push_back(cyc);
      end
      if (bus.pktend_n === 1'b0) begin
         pe_cyc_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n0;
      int p0;
      int ok;

      reset_n         = 1'b0;
      enable          = 1'b1;
      flush           = 1'b0;
      bus.s_data      = '0;
      bus.s_valid     = 1'b0;
      bus.flag_full_n = 1'b1;
`ifdef FX2_STREAM_TESTPAT_EN
      testpat         = 1'b0;
`endif

      // ---------------- reset state ----------------
      ticks(3);
      chk("rst_fd",       32'(bus.fd),       32'h0);
      chk("rst_slwr_n",   32'(bus.slwr_n),   32'h1);
      chk("rst_pktend_n", 32'(bus.pktend_n), 32'h1);
      chk("rst_ovf",      32'(ovf_count),    32'h0);
      chk("rst_level",    32'(level),        32'h0);
      reset_n = 1'b1;
      ticks(2);

      // ---------------- 1: single word, flag high ----------------
      n0 = wr_q.size();
      bus.s_data  = 32'hDDCCBBAA;
      bus.s_valid = 1'b1;
      tick();                                   // push edge t
      bus.s_valid = 1'b0;
      chk("t1_level_t",  32'(level),      32'h1);
      chk("t1_slwr_t",   32'(bus.slwr_n), 32'h1);
      tick();                                   // t+1
      chk("t1_slwr_t1",  32'(bus.slwr_n), 32'h1);
      tick();                                   // t+2
      chk("t1_slwr_b0",  32'(bus.slwr_n), 32'h0);
      chk("t1_fd_b0",    32'(bus.fd),     32'hAA);
      tick();
      chk("t1_slwr_b1",  32'(bus.slwr_n), 32'h0);
      chk("t1_fd_b1",    32'(bus.fd),     32'hBB);
      tick();
      chk("t1_slwr_b2",  32'(bus.slwr_n), 32'h0);
      chk("t1_fd_b2",    32'(bus.fd),     32'hCC);
      tick();
      chk("t1_slwr_b3",  32'(bus.slwr_n), 32'h0);
      chk("t1_fd_b3",    32'(bus.fd),     32'hDD);
      tick();
      chk("t1_slwr_end", 32'(bus.slwr_n), 32'h1);
      chk("t1_writes",   32'(wr_q.size() - n0), 32'd4);
      ticks(2);

      // ---------------- 2: full-flag stall after BB ----------------
      n0 = wr_q.size();
      bus.s_valid = 1'b1;
      tick();                                   // t
      bus.s_valid = 1'b0;
      ticks(2);                                 // t+2
      chk("t2_fd_b0", 32'(bus.fd), 32'hAA);
      tick();                                   // t+3
      chk("t2_fd_b1", 32'(bus.fd), 32'hBB);
      bus.flag_full_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_stall_slwr", 32'(bus.slwr_n), 32'h1);
         chk("t2_stall_fd",   32'(bus.fd),     32'hBB);
      end
      bus.flag_full_n = 1'b1;
      tick();
      chk("t2_slwr_b2", 32'(bus.slwr_n), 32'h0);
      chk("t2_fd_b2",   32'(bus.fd),     32'hCC);
      tick();
      chk("t2_slwr_b3", 32'(bus.slwr_n), 32'h0);
      chk("t2_fd_b3",   32'(bus.fd),     32'hDD);
      tick();
      chk("t2_slwr_end", 32'(bus.slwr_n), 32'h1);
      chk("t2_writes",   32'(wr_q.size() - n0), 32'd4);
      ticks(2);

      // ---------------- 3: overflow with flag low ----------------
      bus.flag_full_n = 1'b0;
      n0 = wr_q.size();
      for (int i = 0; i < 20; i++) begin
         bus.s_data  = 32'h03020100 + 32'(i) * 32'h04040404;
         bus.s_valid = 1'b1;
         tick();
      end
      bus.s_valid = 1'b0;
      tick();
      chk("t3_level_full", 32'(level),     32'd16);
      chk("t3_ovf",        32'(ovf_count), 32'd3);
      chk("t3_no_writes",  32'(wr_q.size() - n0), 32'd0);
      // enable low: a strobe is neither stored nor counted
      enable      = 1'b0;
      bus.s_valid = 1'b1;
      tick();
      bus.s_valid = 1'b0;
      chk("t3_en0_ovf",   32'(ovf_count), 32'd3);
      chk("t3_en0_level", 32'(level),     32'd16);
      // drain with enable still low
      bus.flag_full_n = 1'b1;
      ticks(90);
      chk("t3_writes",      32'(wr_q.size() - n0), 32'd68);
      chk("t3_level_empty", 32'(level),            32'd0);
      ok = 1;
      for (int k = 0; k < 68; k++) begin
         if (n0 + k >= wr_q.size() || wr_q[n0 + k] !== 8'(k)) ok = 0;
      end
      chk("t3_byte_order", 32'(ok), 32'd1);
      enable = 1'b1;

      // ---------------- 3b: push into a full buffer while it pops ----------------
      bus.flag_full_n = 1'b0;
      for (int i = 0; i < 17; i++) begin
         bus.s_data  = 32'(i);
         bus.s_valid = 1'b1;
         tick();
      end
      bus.s_valid = 1'b0;
      chk("t3b_level_full", 32'(level),     32'd16);
      chk("t3b_ovf",        32'(ovf_count), 32'd3);
      bus.flag_full_n = 1'b1;
      ticks(3);                                 // bytes 0..2 of the held word
      bus.s_data  = 32'h11223344;
      bus.s_valid = 1'b1;
      tick();                                   // last byte sent, pop + push
      bus.s_valid = 1'b0;
      chk("t3b_level_pushpop", 32'(level),     32'd16);
      chk("t3b_ovf_pushpop",   32'(ovf_count), 32'd3);
      ticks(90);
      chk("t3b_level_empty", 32'(level), 32'd0);

      // ---------------- 4: flush commits partial packet ----------------
      n0 = wr_q.size();
      p0 = pe_cyc_q.size();
      for (int i = 0; i < 10; i++) begin
         bus.s_data  = 32'hA0A0A0A0 + 32'(i);
         bus.s_valid = 1'b1;
         tick();
      end
      bus.s_valid = 1'b0;
      flush       = 1'b1;
      tick();
      flush       = 1'b0;
      chk("t4_no_early_pktend", 32'(pe_cyc_q.size() - p0), 32'd0);
      ticks(60);
      chk("t4_writes",  32'(wr_q.size() - n0),     32'd40);
      chk("t4_pktends", 32'(pe_cyc_q.size() - p0), 32'd1);
      if (pe_cyc_q.size() > p0 && wr_q.size() > 0) begin
         chk("t4_pktend_after_last", 32'(pe_cyc_q[p0] - wr_cyc_q[wr_cyc_q.size() - 1]), 32'd1);
      end else begin
         chk("t4_pktend_present", 32'(pe_cyc_q.size() - p0), 32'd1);
      end
      p0    = pe_cyc_q.size();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ticks(10);
      chk("t4_second_flush", 32'(pe_cyc_q.size() - p0), 32'd0);

      // ---------------- 5: one full packet, contiguous ----------------
      n0 = wr_q.size();
      p0 = pe_cyc_q.size();
      for (int i = 0; i < 128; i++) begin
         bus.s_data  = {4{8'(i)}};
         bus.s_valid = 1'b1;
         tick();
         bus.s_valid = 1'b0;
         ticks(3);
      end
      ticks(10);
      chk("t5_writes", 32'(wr_q.size() - n0), 32'd512);
      if (wr_cyc_q.size() >= n0 + 512) begin
         chk("t5_contiguous", 32'(wr_cyc_q[n0 + 511] - wr_cyc_q[n0]), 32'd511);
      end else begin
         chk("t5_contiguous_count", 32'(wr_cyc_q.size() - n0), 32'd512);
      end
      chk("t5_no_auto_pktend", 32'(pe_cyc_q.size() - p0), 32'd0);
      chk("t5_ovf", 32'(ovf_count), 32'd3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ticks(10);
      chk("t5_flush_on_wrap", 32'(pe_cyc_q.size() - p0), 32'd0);

      // ---------------- 5b: reset in the middle of a word ----------------
      bus.s_data  = 32'h44332211;
      bus.s_valid = 1'b1;
      tick();                                   // t
      tick();                                   // t+1, second word pushed
      bus.s_valid = 1'b0;
      ticks(2);                                 // t+3: second byte on the bus
      chk("t5b_slwr_mid", 32'(bus.slwr_n), 32'h0);
      chk("t5b_fd_mid",   32'(bus.fd),     32'h22);
      chk("t5b_level_mid", 32'(level),     32'd1);
      reset_n = 1'b0;
      tick();
      chk("t5b_slwr_rst",   32'(bus.slwr_n),   32'h1);
      chk("t5b_level_rst",  32'(level),        32'd0);
      chk("t5b_ovf_rst",    32'(ovf_count),    32'd0);
      chk("t5b_fd_rst",     32'(bus.fd),       32'h0);
      chk("t5b_pktend_rst", 32'(bus.pktend_n), 32'h1);
      reset_n = 1'b1;
      n0 = wr_q.size();
      ticks(10);
      chk("t5b_discarded", 32'(wr_q.size() - n0), 32'd0);

`ifdef FX2_STREAM_TESTPAT_EN
      // ---------------- 6: counter test pattern ----------------
      testpat = 1'b1;
      n0 = wr_q.size();
      for (int i = 0; i < 70; i++) begin
         bus.s_data  = $urandom;
         bus.s_valid = 1'b1;
         tick();
         bus.s_valid = 1'b0;
         ticks(3);
      end
      ticks(10);
      chk("t6_writes", 32'(wr_q.size() - n0), 32'd280);
      ok = 1;
      for (int k = 0; k < 280; k++) begin
         if (n0 + k >= wr_q.size() || wr_q[n0 + k] !== 8'(k)) ok = 0;
      end
      chk("t6_pattern", 32'(ok), 32'd1);
      testpat = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
